// File: rtl/mem_port_arbiter_if.sv
// Memory bus bundle between the port arbiter and the memory.
// Requests use a valid/ready handshake; responses are a single strobe.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_we;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic [DATA_W-1:0]   mem_req_wdata;
    logic [DATA_W/8-1:0] mem_req_wstrb;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wdata,
        output mem_req_wstrb,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wdata,
        input  mem_req_wstrb,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch (IF) and memory access (MA).
// One transaction in flight, MA has priority, flushed fetches are dropped.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    input  logic                if_flush,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    output logic                if_stall_req,

    input  logic                ma_req_valid,
    input  logic                ma_req_we,
    input  logic [ADDR_W-1:0]   ma_req_addr,
    input  logic [DATA_W-1:0]   ma_req_wdata,
    input  logic [DATA_W/8-1:0] ma_req_wstrb,
    output logic                ma_rsp_valid,
    output logic [DATA_W-1:0]   ma_rsp_data,
    output logic                ma_stall_req,

    mem_port_arbiter_if.master  mem
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_MA
    } owner_t;

    state_t              state_q;
    state_t              state_d;
    owner_t              owner_q;
    logic                drop_q;

    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [STRB_W-1:0]   req_wstrb_q;

    logic [DATA_W-1:0]   if_data_q;
    logic [DATA_W-1:0]   ma_data_q;

    logic                grant_ma;
    logic                grant_if;
    logic                rsp_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, hold REQ until accepted, WAIT for data
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (ma_req_valid || (if_req_valid && !if_flush)) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: bus drive, response routing, stalls and data hold mux
    always_comb begin
        grant_ma           = (state_q == S_IDLE) && ma_req_valid;
        grant_if           = (state_q == S_IDLE) && !ma_req_valid &&
                             if_req_valid && !if_flush;
        rsp_done           = (state_q == S_WAIT) && mem.mem_rsp_valid;

        mem.mem_req_valid  = (state_q == S_REQ);
        mem.mem_req_we     = req_we_q;
        mem.mem_req_addr   = req_addr_q;
        mem.mem_req_wdata  = req_wdata_q;
        mem.mem_req_wstrb  = req_wstrb_q;

        ma_rsp_valid       = rsp_done && (owner_q == OWN_MA);
        if_rsp_valid       = rsp_done && (owner_q == OWN_IF) &&
                             !drop_q && !if_flush;

        if_rsp_data        = if_rsp_valid ? mem.mem_rsp_data : if_data_q;
        ma_rsp_data        = ma_rsp_valid ? mem.mem_rsp_data : ma_data_q;

        if_stall_req       = if_req_valid && !if_rsp_valid;
        ma_stall_req       = ma_req_valid && !ma_rsp_valid;
    end

    // Latch the granted requester and its payload for the bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_IF;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
        end else if (grant_ma) begin
            owner_q     <= OWN_MA;
            req_we_q    <= ma_req_we;
            req_addr_q  <= ma_req_addr;
            req_wdata_q <= ma_req_wdata;
            req_wstrb_q <= ma_req_wstrb;
        end else if (grant_if) begin
            owner_q     <= OWN_IF;
            req_we_q    <= 1'b0;
            req_addr_q  <= if_req_addr;
            req_wdata_q <= '0;
            req_wstrb_q <= '1;
        end
    end

    // A redirect while a fetch is on the bus swallows its response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else if (rsp_done) begin
            drop_q <= 1'b0;
        end else if (if_flush && (owner_q == OWN_IF) &&
                     ((state_q == S_REQ) || (state_q == S_WAIT))) begin
            drop_q <= 1'b1;
        end
    end

    // Remember the last delivered data so the idle side stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_data_q <= '0;
            ma_data_q <= '0;
        end else begin
            if (if_rsp_valid) begin
                if_data_q <= mem.mem_rsp_data;
            end
            if (ma_rsp_valid) begin
                ma_data_q <= mem.mem_rsp_data;
            end
        end
    end

endmodule
